// File: rtl/exception_controller.sv
// Exception/eret/interrupt arbiter for the multi-cycle MIPS core: one-cycle CP0 commit, then a fixed flush.
// Optional external interrupts are compiled in when the EXT_IRQ_EN macro is defined.
module exception_controller #(
    parameter int IRQ_WIDTH    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 syscall_req,
    input  logic                 break_req,
    input  logic                 teq_req,
    input  logic                 eret_req,
    input  logic [IRQ_WIDTH-1:0] ext_irq,
    input  logic                 pipeline_stall,
    input  logic [31:0]          instr_pc,
    input  logic [31:0]          status_in,
    output logic                 exception_signal,
    output logic                 eret_signal,
    output logic [4:0]           cause_code,
    output logic [31:0]          program_counter,
    output logic                 redirect_out,
    output logic                 flush_out,
    output logic                 busy,
    output logic [IRQ_WIDTH-1:0] irq_pending
);

    typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_t;

    state_t      state, next_state;
    logic [3:0]  flush_cnt;
    logic        kind_eret;
    logic [4:0]  cause_q;
    logic [31:0] pc_q;

    logic        global_en, el_sys, el_brk, el_teq, any_sync;
    logic        irq_take, accept;
    logic [4:0]  sel_cause;

    assign global_en = status_in[0];
    assign el_sys    = global_en & status_in[1] & syscall_req;
    assign el_brk    = global_en & status_in[2] & break_req;
    assign el_teq    = global_en & status_in[3] & teq_req;
    assign any_sync  = syscall_req | break_req | teq_req | eret_req;
    assign accept    = (state == IDLE) & ~pipeline_stall &
                       (eret_req | el_sys | el_brk | el_teq | irq_take);

    // Priority among eligible exceptions; an interrupt is the fallback (cause 0)
    always_comb begin
        sel_cause = 5'b00000;
        if (el_sys)      sel_cause = 5'b01000;
        else if (el_brk) sel_cause = 5'b01001;
        else if (el_teq) sel_cause = 5'b01101;
    end

`ifdef EXT_IRQ_EN
    logic [IRQ_WIDTH-1:0] irq_prev, irq_pend_q;
    logic                 unused_bits;

    // New edges win over the clear that happens when an interrupt is committed
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            irq_prev   <= '0;
            irq_pend_q <= '0;
        end else begin
            irq_prev   <= ext_irq;
            irq_pend_q <= ((accept & irq_take) ? '0 : irq_pend_q) | (ext_irq & ~irq_prev);
        end
    end

    assign irq_take    = global_en & status_in[4] & (|irq_pend_q) & ~any_sync;
    assign irq_pending = irq_pend_q;
    assign unused_bits = ^status_in[31:5];
`else
    logic unused_bits;

    assign irq_take    = 1'b0;
    assign irq_pending = '0;
    assign unused_bits = ^{status_in[31:4], ext_irq};
`endif

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = COMMIT;
            COMMIT:  next_state = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
            FLUSH:   if (flush_cnt <= 4'd1) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Flush counter and the captured event; eret updates the EPC copy but leaves the cause alone
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            flush_cnt <= 4'd0;
            kind_eret <= 1'b0;
            cause_q   <= 5'b0;
            pc_q      <= 32'b0;
        end else begin
            case (state)
                COMMIT:  flush_cnt <= 4'(FLUSH_CYCLES - 1);
                FLUSH:   flush_cnt <= flush_cnt - 4'd1;
                default: flush_cnt <= 4'd0;
            endcase
            if (accept) begin
                kind_eret <= eret_req;
                pc_q      <= instr_pc;
                if (!eret_req) cause_q <= sel_cause;
            end
        end
    end

    always_comb begin
        exception_signal = (state == COMMIT) & ~kind_eret;
        eret_signal      = (state == COMMIT) & kind_eret;
        redirect_out     = (state == COMMIT);
        flush_out        = (state == COMMIT) | (state == FLUSH);
        busy             = (state == COMMIT) | (state == FLUSH);
        cause_code       = cause_q;
        program_counter  = pc_q;
    end

endmodule

// File: doc/exception_controller.md
# exception_controller

Arbitrates instruction-synchronous exceptions (syscall, break, teq), eret, and optional external interrupts for the multi-cycle MIPS core. It drives the coprocessor 0 exception/eret inputs and the core's redirect/flush controls. Requests are sampled, masked against the CP0 status word, and prioritised. Each accepted event becomes a one-cycle commit pulse followed by a fixed-length pipeline flush. The block sits between the instruction decode/execute stage and coprocessor 0.

## Interface
- IRQ_WIDTH, 4, number of external interrupt lines.
- FLUSH_CYCLES, 2, cycles `flush_out` is held after a commit (1..15).
- clk_in  input  1  core clock; all state updates on the rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- syscall_req  input  1  decoded syscall in execute, level.
- break_req  input  1  decoded break in execute, level.
- teq_req  input  1  teq with equal operands in execute, level.
- eret_req  input  1  decoded eret in execute, level.
- ext_irq  input  IRQ_WIDTH  external interrupt lines, level, asynchronous-safe (synchronised by sender).
- pipeline_stall  input  1  core stalled; no request is accepted while high.
- instr_pc  input  32  PC of the instruction presenting the request.
- status_in  input  32  CP0 status word.
- exception_signal  output  1  one-cycle exception commit to CP0.
- eret_signal  output  1  one-cycle eret commit to CP0.
- cause_code  output  5  ExcCode for CP0, valid with `exception_signal`.
- program_counter  output  32  EPC value for CP0, valid with `exception_signal`.
- redirect_out  output  1  PC must load CP0 exception address this cycle.
- flush_out  output  1  squash in-flight instructions.
- busy  output  1  commit or flush in progress.
- irq_pending  output  IRQ_WIDTH  latched pending interrupts.

## Operation
- Mask bits: status_in[0] is the global enable.
  - status_in[1] enables syscall, [2] break, [3] teq, [4] interrupts.
  - A source is eligible only when status_in[0] and its own bit are both 1.
  - eret is never masked.
- Priority, highest first: eret, syscall (cause 5'b01000), break (5'b01001), teq (5'b01101), interrupt (5'b00000).
- An interrupt is taken only if no synchronous request is present that cycle, eligible or not.
- A masked synchronous request is ignored. The instruction completes normally and no pulse is issued.
- FSM states:
  - IDLE → COMMIT when `!pipeline_stall` and an eligible event exists. On that edge, capture cause_code, program_counter ← instr_pc, and the event kind.
  - COMMIT (1 cycle): either exception_signal=1 or eret_signal=1, plus redirect_out=1 and flush_out=1. Then → FLUSH if FLUSH_CYCLES>1, else → IDLE.
  - FLUSH: counter loaded with FLUSH_CYCLES-1 and decremented each cycle while flush_out=1. → IDLE when the counter reaches 0.
- busy=1 in COMMIT and FLUSH. All request inputs are ignored while busy, because they belong to squashed instructions.
- Pending interrupts:
  - A rising edge on ext_irq[k] sets irq_pending[k]. This happens in any state, including busy.
  - All pending bits clear on the COMMIT edge of an interrupt event.
  - An edge arriving in that same cycle wins, so its bit stays set.
- The eret commit is not gated by status. CP0 restores status itself.

## Timing
- Reset values:
  - exception_signal, eret_signal, redirect_out, flush_out, busy: 0.
  - cause_code: 5'b0.
  - program_counter: 32'b0.
  - irq_pending: 0.
  - FSM: IDLE; counter 0.
- Latency: a request sampled at edge N commits in cycle N+1. Next acceptance is no earlier than edge N+1+FLUSH_CYCLES.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- cause_code and program_counter hold their last values until the next commit.
- Reset mid-COMMIT or mid-FLUSH returns to IDLE immediately with all outputs 0.
- A request held high across stall cycles is accepted on the first cycle with pipeline_stall=0.

## Configuration
- EXT_IRQ_EN defined: edge detect, irq_pending register, and interrupt arbitration are compiled in.
- EXT_IRQ_EN undefined:
  - ext_irq is ignored and irq_pending is constant 0.
  - Cause 5'b00000 is never generated.
  - Ports remain present.

## Test plan
- Syscall: status_in=32'h3, instr_pc=32'h00400020, syscall_req for 1 cycle. Required next cycle: exception_signal=1, cause_code=5'b01000, program_counter=32'h00400020, redirect_out=1. Then flush_out=1 for 2 cycles total.
- Priority: break_req and teq_req together with status_in=32'hF. Required: cause_code=5'b01001, one exception pulse only.
- Masking: syscall_req with status_in=32'h2 (global off). Required: no exception_signal, busy stays 0.
- Eret: eret_req with status_in=32'h0. Required: eret_signal=1 and redirect_out=1 for one cycle, exception_signal=0.
- Interrupt (EXT_IRQ_EN):
  - ext_irq[2] rises during a syscall flush: irq_pending=4'b0100 is held.
  - After IDLE with status_in=32'h11: cause_code=5'b00000 commit, then irq_pending=0.
- Reset and stall:
  - Assert reset_in during FLUSH: all outputs 0 asynchronously.
  - syscall_req held with pipeline_stall=1 for 3 cycles: commit occurs one cycle after stall drops.
